// File: rtl/booth_pkg.sv
// Shared encodings for the sequential radix-2 Booth multiplier: controller
// states and the per-step add/subtract decision.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_t;

  // Radix-2 Booth recoding of the pair {q[0], q_m1}.
  function automatic booth_op_t boothOp(input logic q0, input logic qm1);
    case ({q0, qm1})
      2'b01:   boothOp = OP_ADD;
      2'b10:   boothOp = OP_SUB;
      default: boothOp = OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// One Booth iteration: conditional add/sub of the multiplicand into the
// accumulator, followed by the arithmetic right shift of {acc, q, q_m1}.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0] acc_i,
  input  logic [WIDTH:0] m_i,
  input  logic           q0_i,
  input  logic           qm1_i,
  output logic [WIDTH:0] acc_o,
  output logic           qMsb_o
);

  logic [WIDTH:0] sum;

  // The bit shifted out of the accumulator LSB becomes the new MSB of q.
  always_comb begin
    sum = acc_i;
    case (boothOp(q0_i, qm1_i))
      OP_ADD:  sum = acc_i + m_i;
      OP_SUB:  sum = acc_i - m_i;
      default: sum = acc_i;
    endcase
    acc_o  = {sum[WIDTH], sum[WIDTH:1]};
    qMsb_o = sum[0];
  end

endmodule

// File: rtl/booth_seq_mult_ctrl.sv
// Iterative signed multiplier: one shared Booth step reused WIDTH times,
// fronted by a start/busy/done handshake with a held product register.
module booth_seq_mult_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t               state_q;
  logic [WIDTH:0]       m_q;
  logic [WIDTH:0]       acc_q;
  logic [WIDTH-1:0]     q_q;
  logic                 qm1_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 busy_q;
  logic                 done_q;

  logic [WIDTH:0]       acc_d;
  logic                 qMsb_d;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc_i  (acc_q),
    .m_i    (m_q),
    .q0_i   (q_q[0]),
    .qm1_i  (qm1_q),
    .acc_o  (acc_d),
    .qMsb_o (qMsb_d)
  );

  // acc is one bit wider than the operands so that subtracting the most
  // negative multiplicand cannot overflow; only its low WIDTH bits are kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            m_q     <= {a[WIDTH-1], a};
            acc_q   <= '0;
            q_q     <= b;
            qm1_q   <= 1'b0;
            cnt_q   <= CNT_W'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q <= acc_d;
          q_q   <= {qMsb_d, q_q[WIDTH-1:1]};
          qm1_q <= q_q[0];
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            product_q <= {acc_d[WIDTH-1:0], qMsb_d, q_q[WIDTH-1:1]};
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_seq_mult_ctrl.sv
// Directed and exhaustive checks of the 4-bit sequential Booth multiplier:
// signs, corners, handshake timing, busy-start rejection and async reset.
module tb_booth_seq_mult_ctrl;

  localparam int WIDTH = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  int vecCount  = 0;
  int failCount = 0;

  booth_seq_mult_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Full handshake: done is expected in the 5th low phase after the start edge.
  task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv,
                               input logic [7:0] expProd, input string tag);
    int waitCycles;
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitCycles = 1;
    while (!done && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput({tag, "_latency"}, 16'(waitCycles), 16'(WIDTH + 1));
    checkOutput({tag, "_product"}, 16'(product), 16'(expProd));
    @(negedge clk);
    checkOutput({tag, "_doneFall"}, 16'(done), 16'd0);
    checkOutput({tag, "_idle"}, 16'(busy), 16'd0);
    checkOutput({tag, "_hold"}, 16'(product), 16'(expProd));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneSeen;
    int p;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    checkOutput("rst_busy", 16'(busy), 16'd0);
    checkOutput("rst_done", 16'(done), 16'd0);
    checkOutput("rst_product", 16'(product), 16'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(4'h3, 4'h2, 8'h06, "p3xp2");
    applyStimulus(4'hD, 4'h4, 8'hF4, "m3xp4");
    applyStimulus(4'h5, 4'hE, 8'hF6, "p5xm2");
    applyStimulus(4'hC, 4'hD, 8'h0C, "m4xm3");
    applyStimulus(4'h8, 4'h8, 8'h40, "m8xm8");
    applyStimulus(4'h8, 4'h7, 8'hC8, "m8xp7");
    applyStimulus(4'h0, 4'hB, 8'h00, "0xm5");
    applyStimulus(4'h7, 4'h7, 8'h31, "p7xp7");

    // Cycle-by-cycle timing of 3*2 with a stray start (1*1) injected during RUN.
    @(negedge clk);
    a     = 4'h3;
    b     = 4'h2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      checkOutput($sformatf("tim_busy_%0d", i), 16'(busy), (i <= 5) ? 16'd1 : 16'd0);
      checkOutput($sformatf("tim_done_%0d", i), 16'(done), (i == 5) ? 16'd1 : 16'd0);
      if (i == 2) begin
        a     = 4'h1;
        b     = 4'h1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput("ignore_product", 16'(product), 16'h0006);
    doneSeen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) doneSeen++;
      @(negedge clk);
    end
    checkOutput("ignore_noSecondDone", 16'(doneSeen), 16'd0);

    // Async reset in the second RUN cycle.
    a     = 4'h3;
    b     = 4'h2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 16'(busy), 16'd0);
    checkOutput("midrst_done", 16'(done), 16'd0);
    checkOutput("midrst_product", 16'(product), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'hC, 4'hD, 8'h0C, "postrst_m4xm3");

    for (int ai = -8; ai < 8; ai++) begin
      for (int bi = -8; bi < 8; bi++) begin
        p = ai * bi;
        applyStimulus(ai[3:0], bi[3:0], p[7:0], $sformatf("sweep_%0d_x_%0d", ai, bi));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule
